fft_batch_accumulator: RTL

- Avalon-ST style sink that receives the packetised batches produced by the raw sample buffer after they pass through the FFT.
- Accumulates RUNS consecutive batches of BATCH_SIZE entries bin-by-bin into an internal array, then exposes the summed spectrum through a registered read port.
- Sits at the FFT output and is the receiving end of the sop/eop/valid/ready batch protocol.

---
 rtl/fft_batch_accumulator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fft_batch_accumulator.sv
// Avalon-ST sink that sums RUNS consecutive FFT batches bin-by-bin and exposes
// the summed spectrum through a registered read port.
module fft_batch_accumulator #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned BATCH_SIZE = 2048,
    parameter int unsigned RUNS       = 4,
    localparam int unsigned ACC_WIDTH = DATA_WIDTH + $clog2(RUNS) + 1,
    localparam int unsigned AW        = $clog2(BATCH_SIZE),
    localparam int unsigned RCW       = $clog2(RUNS + 1)
) (
    input  logic                  sink_clk,
    input  logic                  reset_n,
    input  logic                  sink_valid,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [DATA_WIDTH-1:0] sink_data,
    output logic                  sink_ready,
    input  logic                  clear,
    input  logic [AW-1:0]         result_addr,
    output logic [ACC_WIDTH-1:0]  result_data,
    output logic                  result_valid,
    output logic [RCW-1:0]        run_count,
    output logic                  error
);

    typedef enum logic [1:0] {
        WAIT_SOP,
        RECEIVE,
        DONE
    } state_t;

    localparam logic [AW-1:0]  LAST_POS = AW'(BATCH_SIZE - 1);
    localparam logic [RCW-1:0] RUNS_C   = RCW'(RUNS);

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] acc [BATCH_SIZE];
    logic [AW-1:0]        pos, pos_next;
    logic [RCW-1:0]       run_count_next;
    logic [RCW-1:0]       run_inc;
    logic                 error_next;
    logic                 ready_next;
    logic                 accept;
    logic                 overwrite;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [ACC_WIDTH-1:0] wr_data;

    assign accept       = sink_valid && sink_ready;
    assign run_inc      = run_count + RCW'(1);
    assign result_valid = (state == DONE);

    always_comb begin
        state_next     = state;
        pos_next       = pos;
        run_count_next = run_count;
        error_next     = error;
        wr_en          = 1'b0;
        wr_addr        = pos;
        overwrite      = (run_count == '0);

        if (clear) begin
            state_next     = WAIT_SOP;
            run_count_next = '0;
            error_next     = 1'b0;
        end else if (accept) begin
            case (state)
                WAIT_SOP: begin
                    if (sink_sop) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        pos_next   = AW'(1);
                        state_next = RECEIVE;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (sink_sop) begin
                        // Unexpected sop restarts as run 0, so the beat overwrites bin 0.
                        error_next     = 1'b1;
                        run_count_next = '0;
                        overwrite      = 1'b1;
                        wr_en          = 1'b1;
                        wr_addr        = '0;
                        pos_next       = AW'(1);
                    end else if (pos != LAST_POS) begin
                        if (sink_eop) begin
                            error_next     = 1'b1;
                            run_count_next = '0;
                            state_next     = WAIT_SOP;
                        end else begin
                            wr_en    = 1'b1;
                            pos_next = pos + AW'(1);
                        end
                    end else if (!sink_eop) begin
                        error_next     = 1'b1;
                        run_count_next = '0;
                        state_next     = WAIT_SOP;
                    end else begin
                        wr_en          = 1'b1;
                        run_count_next = run_inc;
                        pos_next       = '0;
                        state_next     = (run_inc == RUNS_C) ? DONE : WAIT_SOP;
                    end
                end
                default: ;
            endcase
        end

        wr_data    = overwrite ? ACC_WIDTH'(sink_data)
                               : acc[wr_addr] + ACC_WIDTH'(sink_data);
        ready_next = (state_next != DONE);
    end

    always_ff @(posedge sink_clk) begin
        if (!reset_n) begin
            state      <= WAIT_SOP;
            pos        <= '0;
            run_count  <= '0;
            error      <= 1'b0;
            sink_ready <= 1'b0;
        end else begin
            state      <= state_next;
            pos        <= pos_next;
            run_count  <= run_count_next;
            error      <= error_next;
            sink_ready <= ready_next;
        end
    end

    always_ff @(posedge sink_clk) begin
        if (reset_n && wr_en) begin
            acc[wr_addr] <= wr_data;
        end
    end

    // Forward a same-edge write so the read port never lags the array.
    always_ff @(posedge sink_clk) begin
        if (!reset_n) begin
            result_data <= '0;
        end else if (wr_en && (wr_addr == result_addr)) begin
            result_data <= wr_data;
        end else begin
            result_data <= acc[result_addr];
        end
    end

endmodule
